// File: rtl/useq_pkg.sv
// useq_pkg: opcodes, decoder select encodings and micro-word layout for the useq_ctrl sequencer.
package useq_pkg;
    localparam int OPW  = 3;
    localparam int UPCW = 2;

    localparam logic [OPW-1:0] OP_NOP   = 3'd0;
    localparam logic [OPW-1:0] OP_LDA   = 3'd1;
    localparam logic [OPW-1:0] OP_LDB   = 3'd2;
    localparam logic [OPW-1:0] OP_LDOP  = 3'd3;
    localparam logic [OPW-1:0] OP_MOVAB = 3'd4;
    localparam logic [OPW-1:0] OP_MOVBA = 3'd5;
    localparam logic [OPW-1:0] OP_EXEC  = 3'd6;
    localparam logic [OPW-1:0] OP_LDALL = 3'd7;

    localparam logic [2:0] RS_NONE   = 3'b000;
    localparam logic [2:0] RS_IMM_A  = 3'b001;
    localparam logic [2:0] RS_BUS_A  = 3'b010;
    localparam logic [2:0] RS_IMM_B  = 3'b011;
    localparam logic [2:0] RS_BUS_B  = 3'b100;
    localparam logic [2:0] RS_IMM_OP = 3'b101;

    localparam logic [1:0] WS_NONE = 2'b00;
    localparam logic [1:0] WS_A    = 2'b01;
    localparam logic [1:0] WS_B    = 2'b10;
    localparam logic [1:0] WS_OP   = 2'b11;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [2:0] rs;
        logic [1:0] ws;
        logic       alu_go;
        logic       alu_oe;
        logic       last;
    } uword_t;
endpackage

// File: rtl/useq_rom.sv
// useq_rom: combinational microcode ROM mapping (opcode, micro-PC) to a micro-word.
module useq_rom
    import useq_pkg::*;
(
    input  logic [OPW-1:0]  opcode,
    input  logic [UPCW-1:0] upc,
    output uword_t          uw
);
    always_comb begin
        uw = '{rs: RS_NONE, ws: WS_NONE, alu_go: 1'b0, alu_oe: 1'b0, last: 1'b1};
        case (opcode)
            OP_LDA:   uw.rs = RS_IMM_A;
            OP_LDB:   uw.rs = RS_IMM_B;
            OP_LDOP:  uw.rs = RS_IMM_OP;
            OP_MOVAB: begin uw.rs = RS_BUS_B; uw.ws = WS_A; end
            OP_MOVBA: begin uw.rs = RS_BUS_A; uw.ws = WS_B; end
            OP_EXEC: begin
                uw.rs     = (upc == 2'd0) ? RS_NONE : RS_BUS_A;
                uw.alu_go = (upc == 2'd0);
                uw.alu_oe = (upc != 2'd0);
                uw.last   = (upc != 2'd0);
            end
            OP_LDALL: begin
                uw.rs   = (upc == 2'd0) ? RS_IMM_A : (upc == 2'd1) ? RS_IMM_B : RS_IMM_OP;
                uw.last = (upc >= 2'd2);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/useq_ctrl.sv
// useq_ctrl: microcode sequencer FSM and opcode handshake; USEQ_OVERLAP_EN allows zero-bubble back-to-back issue.
module useq_ctrl
    import useq_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic [OPW-1:0] opcode,
    input  logic           hold,
    output logic [2:0]     rs,
    output logic [1:0]     ws,
    output logic           alu_go,
    output logic           alu_oe,
    output logic           busy,
    output logic           done
);
    state_t          state_q, state_d;
    logic [OPW-1:0]  opcode_q, opcode_d;
    logic [UPCW-1:0] upc_q, upc_d;
    uword_t          uw;
    logic            active, take;

    useq_rom u_rom (.opcode(opcode_q), .upc(upc_q), .uw(uw));

    always_comb begin
        busy   = (state_q == RUN);
        active = busy && !hold;
        rs     = active ? uw.rs : RS_NONE;
        ws     = active ? uw.ws : WS_NONE;
        alu_go = active && uw.alu_go;
        alu_oe = active && uw.alu_oe;
        done   = active && uw.last;
`ifdef USEQ_OVERLAP_EN
        instr_ready = !busy || done;
`else
        instr_ready = !busy;
`endif
        take     = instr_valid && instr_ready;
        state_d  = state_q;
        opcode_d = opcode_q;
        upc_d    = upc_q;
        if (take) begin
            state_d  = RUN;
            opcode_d = opcode;
            upc_d    = '0;
        end else if (active) begin
            state_d = uw.last ? IDLE : RUN;
            upc_d   = uw.last ? upc_q : upc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            upc_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            upc_q    <= upc_d;
        end
    end
endmodule

// File: doc/useq_ctrl.md
Name: useq_ctrl

Overview:
- Microcode sequencer that sits directly upstream of the register-file buffer-enable decoder.
- Accepts a 3-bit opcode over a valid/ready handshake and steps a micro-PC through a fixed microcode ROM.
- Drives the decoder's read-select (rs) and write-select (ws) fields, plus ALU strobes, one micro-step per clock.
- Produces a done pulse on the final micro-step of each instruction.

Parameters:
- OPW, 3, opcode width (8 instructions).
- UPCW, 2, micro-PC width (max 4 steps per instruction).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  opcode offered.
- instr_ready  output  1  sequencer can accept an opcode.
- opcode  input  OPW  instruction opcode, sampled on handshake.
- hold  input  1  stall: freezes the micro-PC and masks all strobes.
- rs  output  3  read-select to decoder (0 = none).
- ws  output  2  write-select to decoder (0 = none).
- alu_go  output  1  ALU compute strobe.
- alu_oe  output  1  ALU drives bus.
- busy  output  1  an instruction is executing.
- done  output  1  high during the final micro-step of an instruction.

Behaviour:
- State: IDLE, RUN. Registers: opcode_q[OPW], upc_q[UPCW].
- Reset (async, rst_n=0): state=IDLE, opcode_q=0, upc_q=0; every output except instr_ready is 0 immediately; instr_ready=1.
- Handshake:
  - instr_ready=1 in IDLE (see the optional feature for RUN).
  - Transfer occurs on a rising edge with instr_valid & instr_ready.
  - On transfer: opcode_q<=opcode, upc_q<=0, state<=RUN.
  - instr_valid with ready low is ignored; opcode need not be held stable outside the transfer edge.
- Outputs are combinational from (state, opcode_q, upc_q, hold). In IDLE, or while hold=1, rs=0, ws=0, alu_go=0, alu_oe=0, done=0.
- busy=1 whenever state=RUN, including while hold=1.
- Latency: transfer at edge E → step 0 visible in the cycle after E; an instruction of N steps occupies N cycles plus any hold cycles.
- Advance: in RUN with hold=0, each edge sets upc_q+1 if the current step is not last; otherwise state<=IDLE (or reload per the optional feature). With hold=1, no state change.
- Microcode (per step: rs,ws,alu_go,alu_oe; last step marked *):
  - 0 NOP: s0* 0,0,0,0.
  - 1 LDA: s0* 001,00,0,0.
  - 2 LDB: s0* 011,00,0,0.
  - 3 LDOP: s0* 101,00,0,0.
  - 4 MOVAB: s0* 100,01,0,0 (A→bus→B).
  - 5 MOVBA: s0* 010,10,0,0.
  - 6 EXEC: s0 000,00,1,0; s1* 010,00,0,1 (ALU→bus→A).
  - 7 LDALL: s0 001,00,0,0; s1 011,00,0,0; s2* 101,00,0,0.
- Invariants:
  - rs never takes 110/111; ws=11 is never emitted (reserved).
  - upc_q never exceeds the last step of opcode_q.
- Reset mid-instruction: instruction abandoned; no done pulse is produced.

Optional Feature:
- USEQ_OVERLAP_EN defined:
  - instr_ready is also 1 during the final micro-step with hold=0.
  - A transfer on that edge loads the new opcode at upc 0 and keeps state RUN, giving zero bubble.
  - done and the next instruction's step 0 are in consecutive cycles.
- Undefined:
  - instr_ready=1 only in IDLE.
  - At least one idle cycle separates instructions.

Decomposition:
- Package useq_pkg:
  - opcode localparams (OP_NOP..OP_LDALL).
  - RS_*/WS_* encodings matching the decoder (RS_IMM_A=001, RS_BUS_A=010, RS_IMM_B=011, RS_BUS_B=100, RS_IMM_OP=101; WS_A=01, WS_B=10, WS_OP=11).
  - Micro-word field layout {rs,ws,alu_go,alu_oe,last}.
- Sub-module useq_rom: purely combinational (opcode, upc) → micro-word.
- Sequencer holds only the FSM and handshake.

Test Plan:
- Reset then opcode=1 with valid pulsed for 1 cycle → the next cycle shows rs=001, done=1, busy=1; the cycle after that shows instr_ready=1, busy=0.
- opcode=6 → step 0: alu_go=1, rs=0; step 1: alu_oe=1, rs=010, done=1; exactly 2 busy cycles.
- opcode=7 with hold=1 on the second step cycle → rs sequence 001, 000, 011, 101; done only in the 4th cycle.
- Assert rst_n=0 mid-way through opcode=7 (step 1) → outputs 0 asynchronously, no done; after release instr_ready=1.
- Back-to-back opcodes 4 then 5 with valid held high:
  - Without USEQ_OVERLAP_EN: rs 100, 000, 010.
  - With USEQ_OVERLAP_EN: rs 100, 010.
- Random opcode stream for 1000 instructions → rs ∉ {110,111}, ws≠11, and done count equals accepted count.
